// File: rtl/sync_event_accum_pkg.sv
// Shared types and sizing helpers for the source-side event accumulator.
// The gap FSM state and a constant clog2 are used to size the gap counter.
package sync_event_pkg;

  typedef enum logic {
    ARMED = 1'b0,
    HOLD  = 1'b1
  } gap_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_event_accum_if.sv
// Event-in / token-out bundle between the event source and the accumulator.
// The master drives events, FIFO status and overflow clear; the slave returns status.
interface sync_event_accum_if #(
  parameter int CNTW = 8,
  parameter int AMTW = 4
);
  logic            sINC;
  logic [AMTW-1:0] sINC_AMT;
  logic            sFULL_N;
  logic            sOVF_CLR;
  logic            sENQ;
  logic            sOVF;
  logic [CNTW-1:0] sPENDING;
  logic            sIDLE;

  modport master (
    output sINC, sINC_AMT, sFULL_N, sOVF_CLR,
    input  sENQ, sOVF, sPENDING, sIDLE
  );

  modport slave (
    input  sINC, sINC_AMT, sFULL_N, sOVF_CLR,
    output sENQ, sOVF, sPENDING, sIDLE
  );
endinterface

// File: rtl/sync_event_accum_cntr.sv
// Saturating up/down counter: adds inc_amt_i, subtracts dec_i, one-cycle update.
// ovf_o strobes combinationally in any cycle whose sum would exceed the maximum.
module sat_add_sub_cntr #(
  parameter int CNTW = 8,
  parameter int AMTW = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AMTW-1:0] inc_amt_i,
  input  logic            dec_i,
  output logic [CNTW-1:0] cnt_o,
  output logic            ovf_o
);
  // One spare bit above the widest operand so the sum never wraps.
  localparam int SW = ((CNTW > AMTW) ? CNTW : AMTW) + 1;
  localparam logic [SW-1:0] MAXV = {{(SW - CNTW){1'b0}}, {CNTW{1'b1}}};

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SW-1:0]   sum;

  always_comb begin
    sum   = SW'(cnt_q) + SW'(inc_amt_i) - SW'(dec_i);
    ovf_o = (sum > MAXV);
    cnt_d = ovf_o ? {CNTW{1'b1}} : sum[CNTW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/sync_event_accum.sv
// Accumulates event pulses and drains them one token per sENQ into the token FIFO.
// Events count at the arrival edge (earliest sENQ next cycle); waits while sFULL_N=0, GAP idles between tokens.
module sync_event_accum
  import sync_event_pkg::*;
#(
  parameter int CNTW = 8,
  parameter int AMTW = 4,
  parameter int GAP  = 0
) (
  input  logic              sCLK,
  input  logic              sRST,
  sync_event_accum_if.slave ev
);
  localparam int GCW = (clog2(GAP + 1) > 4) ? clog2(GAP + 1) : 4;
  localparam logic [GCW-1:0] GLOAD = (GAP > 0) ? GCW'(GAP - 1) : {GCW{1'b0}};

  gap_state_e      state_q, state_d;
  logic [GCW-1:0]  gcnt_q, gcnt_d;
  logic [CNTW-1:0] cnt;
  logic [AMTW-1:0] inc_amt;
  logic            enq;
  logic            ovf_stb;
  logic            ovf_q, ovf_d;

  assign inc_amt = ev.sINC ? ev.sINC_AMT : '0;

  // Only registered state and sFULL_N feed the enqueue path.
  assign enq = (state_q == ARMED) && (cnt != '0) && ev.sFULL_N && !sRST;

  sat_add_sub_cntr #(
    .CNTW(CNTW),
    .AMTW(AMTW)
  ) u_cntr (
    .clk_i    (sCLK),
    .rst_i    (sRST),
    .inc_amt_i(inc_amt),
    .dec_i    (enq),
    .cnt_o    (cnt),
    .ovf_o    (ovf_stb)
  );

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      ARMED: begin
        if (enq && (GAP > 0)) begin
          state_d = HOLD;
          gcnt_d  = GLOAD;
        end
      end
      HOLD: begin
        if (gcnt_q == '0) state_d = ARMED;
        else              gcnt_d  = gcnt_q - 1'b1;
      end
      default: state_d = ARMED;
    endcase
  end

  // A fresh overflow beats a simultaneous clear.
  assign ovf_d = ovf_stb | (ovf_q & ~ev.sOVF_CLR);

  always_ff @(posedge sCLK) begin
    if (sRST) begin
      state_q <= ARMED;
      gcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ev.sENQ     = enq;
  assign ev.sOVF     = ovf_q;
  assign ev.sPENDING = cnt;
  assign ev.sIDLE    = (cnt == '0) && (state_q == ARMED);
endmodule
